// File: rtl/wb_cdb_if.sv
// Writeback-source to CDB bundle between the execution units and the arbiter.
// The master drives the per-source writeback packets and flush; the slave returns the CDB.
interface wb_cdb_if #(
   parameter int NUM_SRC      = 4,
   parameter int ROB_ENTRY    = 16,
   parameter int NUM_PHYS_REG = 32,
   parameter int WORD_SIZE_P  = 16,
   parameter int FLAG_W       = 4
);
   localparam int RW = $clog2(ROB_ENTRY);
   localparam int PW = $clog2(NUM_PHYS_REG);
   localparam int SW = $clog2(NUM_SRC);

   logic [NUM_SRC-1:0]             wb_v_i;
   logic [NUM_SRC*RW-1:0]          wb_rob_dest_i;
   logic [NUM_SRC*PW-1:0]          wb_reg_dest_i;
   logic [NUM_SRC*WORD_SIZE_P-1:0] wb_result_i;
   logic [NUM_SRC*FLAG_W-1:0]      wb_flags_i;
   logic                           mispredict_i;
   logic [NUM_SRC-1:0]             src_afull_o;
   logic                           cdb_v_o;
   logic [RW-1:0]                  cdb_rob_dest_o;
   logic [PW-1:0]                  cdb_reg_dest_o;
   logic [WORD_SIZE_P-1:0]         cdb_result_o;
   logic [FLAG_W-1:0]              cdb_flags_o;
   logic [SW-1:0]                  cdb_src_o;
   logic                           overflow_o;

   modport master (
      output wb_v_i, wb_rob_dest_i, wb_reg_dest_i,
      output wb_result_i, wb_flags_i, mispredict_i,
      input  src_afull_o, cdb_v_o, cdb_rob_dest_o,
      input  cdb_reg_dest_o, cdb_result_o, cdb_flags_o,
      input  cdb_src_o, overflow_o
   );

   modport slave (
      input  wb_v_i, wb_rob_dest_i, wb_reg_dest_i,
      input  wb_result_i, wb_flags_i, mispredict_i,
      output src_afull_o, cdb_v_o, cdb_rob_dest_o,
      output cdb_reg_dest_o, cdb_result_o, cdb_flags_o,
      output cdb_src_o, overflow_o
   );
endinterface

// File: rtl/wb_cdb_arbiter.sv
// Per-source writeback FIFOs with a round-robin grant onto one registered CDB.
// Optional WB_BYPASS_EN lets an empty source compete with its live input.
module wb_cdb_arbiter #(
   parameter int NUM_SRC      = 4,
   parameter int FIFO_DEPTH   = 4,
   parameter int AFULL_LVL    = 2,
   parameter int WORD_SIZE_P  = 16,
   parameter int ROB_ENTRY    = 16,
   parameter int NUM_PHYS_REG = 32,
   parameter int FLAG_W       = 4
) (
   input logic   clk_i,
   input logic   reset_i,
   wb_cdb_if.slave bus
);
   localparam int RW  = $clog2(ROB_ENTRY);
   localparam int PW  = $clog2(NUM_PHYS_REG);
   localparam int SW  = $clog2(NUM_SRC);
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int CW  = AW + 1;
   localparam int PKW = RW + PW + WORD_SIZE_P + FLAG_W;

   logic [PKW-1:0] mem_q [NUM_SRC][FIFO_DEPTH];
   logic [PKW-1:0] mem_d [NUM_SRC][FIFO_DEPTH];
   logic [AW-1:0]  wr_q [NUM_SRC];
   logic [AW-1:0]  wr_d [NUM_SRC];
   logic [AW-1:0]  rd_q [NUM_SRC];
   logic [AW-1:0]  rd_d [NUM_SRC];
   logic [CW-1:0]  cnt_q [NUM_SRC];
   logic [CW-1:0]  cnt_d [NUM_SRC];
   logic [SW-1:0]  last_q, last_d;
   logic           ovf_q, ovf_d;
   logic           cdb_v_q, cdb_v_d;
   logic [PKW-1:0] cdb_pkt_q, cdb_pkt_d;
   logic [SW-1:0]  cdb_src_q, cdb_src_d;

   logic [PKW-1:0]     in_pkt [NUM_SRC];
   logic [NUM_SRC-1:0] byp, req, pop, push, acc;
   logic [NUM_SRC-1:0] afull;
   logic               gnt_v;
   logic [SW-1:0]      gnt_idx;
   logic [SW-1:0]      cand;

   always_comb begin
      for (int s = 0; s < NUM_SRC; s++) begin
         in_pkt[s] = {bus.wb_rob_dest_i[s*RW +: RW],
                      bus.wb_reg_dest_i[s*PW +: PW],
                      bus.wb_result_i[s*WORD_SIZE_P +: WORD_SIZE_P],
                      bus.wb_flags_i[s*FLAG_W +: FLAG_W]};
      end
   end

   // Candidates: non-empty heads, plus live inputs of empty FIFOs when bypassing.
   always_comb begin
      byp = '0;
`ifdef WB_BYPASS_EN
      for (int s = 0; s < NUM_SRC; s++) begin
         byp[s] = (cnt_q[s] == '0) && bus.wb_v_i[s] && !bus.mispredict_i;
      end
`endif
      for (int s = 0; s < NUM_SRC; s++) begin
         req[s] = ((cnt_q[s] != '0) || byp[s]) && !bus.mispredict_i;
      end
      gnt_v   = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         cand = SW'((int'(last_q) + 1 + i) % NUM_SRC);
         if (!gnt_v && req[cand]) begin
            gnt_v   = 1'b1;
            gnt_idx = cand;
         end
      end
   end

   always_comb begin
      mem_d     = mem_q;
      wr_d      = wr_q;
      rd_d      = rd_q;
      cnt_d     = cnt_q;
      last_d    = last_q;
      ovf_d     = ovf_q;
      cdb_v_d   = gnt_v;
      cdb_pkt_d = cdb_pkt_q;
      cdb_src_d = cdb_src_q;
      pop       = '0;
      push      = '0;
      acc       = '0;
      if (gnt_v) begin
         last_d    = gnt_idx;
         cdb_src_d = gnt_idx;
         if (byp[gnt_idx]) begin
            cdb_pkt_d = in_pkt[gnt_idx];
         end else begin
            cdb_pkt_d    = mem_q[gnt_idx][rd_q[gnt_idx]];
            pop[gnt_idx] = 1'b1;
         end
      end
      for (int s = 0; s < NUM_SRC; s++) begin
         acc[s] = bus.wb_v_i[s] && !bus.mispredict_i &&
                  !(gnt_v && byp[s] && (gnt_idx == SW'(s)));
         // A full FIFO still takes a push when its head leaves this cycle.
         push[s] = acc[s] &&
                   ((cnt_q[s] != CW'(FIFO_DEPTH)) || pop[s]);
         if (acc[s] && !push[s]) begin
            ovf_d = 1'b1;
         end
         if (push[s]) begin
            mem_d[s][wr_q[s]] = in_pkt[s];
            wr_d[s] = wr_q[s] + AW'(1);
         end
         if (pop[s]) begin
            rd_d[s] = rd_q[s] + AW'(1);
         end
         case ({push[s], pop[s]})
            2'b10:   cnt_d[s] = cnt_q[s] + CW'(1);
            2'b01:   cnt_d[s] = cnt_q[s] - CW'(1);
            default: cnt_d[s] = cnt_q[s];
         endcase
         if (bus.mispredict_i) begin
            wr_d[s]  = '0;
            rd_d[s]  = '0;
            cnt_d[s] = '0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_q      <= '{default: '0};
         rd_q      <= '{default: '0};
         cnt_q     <= '{default: '0};
         last_q    <= SW'(NUM_SRC - 1);
         ovf_q     <= 1'b0;
         cdb_v_q   <= 1'b0;
         cdb_pkt_q <= '0;
         cdb_src_q <= '0;
      end else begin
         wr_q      <= wr_d;
         rd_q      <= rd_d;
         cnt_q     <= cnt_d;
         last_q    <= last_d;
         ovf_q     <= ovf_d;
         cdb_v_q   <= cdb_v_d;
         cdb_pkt_q <= cdb_pkt_d;
         cdb_src_q <= cdb_src_d;
      end
   end

   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

   always_comb begin
      for (int s = 0; s < NUM_SRC; s++) begin
         afull[s] = cnt_q[s] >= CW'(AFULL_LVL);
      end
   end

   assign bus.src_afull_o = afull;
   assign bus.cdb_v_o     = cdb_v_q;
   assign bus.cdb_src_o   = cdb_src_q;
   assign bus.overflow_o  = ovf_q;
   assign {bus.cdb_rob_dest_o, bus.cdb_reg_dest_o,
           bus.cdb_result_o, bus.cdb_flags_o} = cdb_pkt_q;
endmodule

// File: tb/tb_wb_cdb_arbiter.sv
// Scoreboarded bench for wb_cdb_arbiter: per-source expected queues
// filled at drive time and drained by a CDB monitor.
module tb_wb_cdb_arbiter;
   localparam int NS = 4;
   localparam int DEP = 4;
`ifdef WB_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   typedef struct packed {
      logic [3:0]  rob;
      logic [4:0]  rg;
      logic [15:0] res;
      logic [3:0]  flg;
   } pkt_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   wb_cdb_if #(.NUM_SRC(NS), .ROB_ENTRY(16), .NUM_PHYS_REG(32),
               .WORD_SIZE_P(16), .FLAG_W(4)) bus ();

   wb_cdb_arbiter #(.NUM_SRC(NS), .FIFO_DEPTH(DEP), .AFULL_LVL(2),
                    .WORD_SIZE_P(16), .ROB_ENTRY(16),
                    .NUM_PHYS_REG(32), .FLAG_W(4)) dut (
      .clk_i   (clk),
      .reset_i (rst),
      .bus     (bus)
   );

   pkt_t sbq [NS][$];
   int   glog [$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   mon_s;
   pkt_t mon_got, mon_exp;

   always @(negedge clk) begin
      if (!rst && bus.cdb_v_o === 1'b1) begin
         mon_s   = int'(bus.cdb_src_o);
         mon_got = '{bus.cdb_rob_dest_o, bus.cdb_reg_dest_o,
                     bus.cdb_result_o, bus.cdb_flags_o};
         glog.push_back(mon_s);
         n_cmp++;
         if (sbq[mon_s].size() == 0) begin
            n_bad++;
            $display("FAIL cdb_unexpected src=%0d got=%h required none",
                     mon_s, mon_got);
         end else begin
            mon_exp = sbq[mon_s].pop_front();
            if (mon_got !== mon_exp) begin
               n_bad++;
               $display("FAIL cdb_pkt src=%0d got=%h required %h",
                        mon_s, mon_got, mon_exp);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.wb_v_i       = '0;
      bus.mispredict_i = 1'b0;
   endtask

   task automatic clear_sb();
      for (int s = 0; s < NS; s++) sbq[s].delete();
   endtask

   task automatic put(input int s, input logic [3:0] rob,
                      input logic [4:0] rg, input logic [15:0] res,
                      input logic [3:0] flg, input bit keep);
      bus.wb_v_i[s]               = 1'b1;
      bus.wb_rob_dest_i[s*4 +: 4] = rob;
      bus.wb_reg_dest_i[s*5 +: 5] = rg;
      bus.wb_result_i[s*16 +: 16] = res;
      bus.wb_flags_i[s*4 +: 4]    = flg;
      if (keep) sbq[s].push_back('{rob, rg, res, flg});
   endtask

   function automatic int pending();
      int n = 0;
      for (int s = 0; s < NS; s++) n += sbq[s].size();
      return n;
   endfunction

   task automatic drain(input string tag);
      for (int k = 0; k < 200 && pending() != 0; k++) step();
      repeat (3) step();
      n_cmp++;
      if (pending() != 0) begin
         n_bad++;
         $display("FAIL %s_drain pending=%0d required 0", tag, pending());
      end
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      idle();
      clear_sb();
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      step();
      step();
      n_cmp += 8;
      if (bus.cdb_v_o !== 1'b0) begin
         n_bad++; $display("FAIL rst_v got=%b required 0", bus.cdb_v_o);
      end
      if (bus.cdb_rob_dest_o !== 4'd0) begin
         n_bad++; $display("FAIL rst_rob got=%h required 0", bus.cdb_rob_dest_o);
      end
      if (bus.cdb_reg_dest_o !== 5'd0) begin
         n_bad++; $display("FAIL rst_reg got=%h required 0", bus.cdb_reg_dest_o);
      end
      if (bus.cdb_result_o !== 16'd0) begin
         n_bad++; $display("FAIL rst_res got=%h required 0", bus.cdb_result_o);
      end
      if (bus.cdb_flags_o !== 4'd0) begin
         n_bad++; $display("FAIL rst_flg got=%h required 0", bus.cdb_flags_o);
      end
      if (bus.cdb_src_o !== 2'd0) begin
         n_bad++; $display("FAIL rst_src got=%h required 0", bus.cdb_src_o);
      end
      if (bus.src_afull_o !== 4'd0) begin
         n_bad++; $display("FAIL rst_afull got=%b required 0", bus.src_afull_o);
      end
      if (bus.overflow_o !== 1'b0) begin
         n_bad++; $display("FAIL rst_ovf got=%b required 0", bus.overflow_o);
      end
      rst = 1'b0;
   endtask

   task automatic test_single();
      apply_reset();
      repeat (5) step();
      put(1, 4'd3, 5'd17, 16'h00C8, 4'h5, 1'b1);
      for (int k = 1; k <= 4; k++) begin
         step();
         if (k == 1) idle();
         n_cmp++;
         if (bus.cdb_v_o !== (k == LAT)) begin
            n_bad++;
            $display("FAIL single_v cyc=+%0d got=%b required %b",
                     k, bus.cdb_v_o, (k == LAT));
         end
         if (k == LAT) begin
            n_cmp++;
            if (bus.cdb_src_o !== 2'd1 || bus.cdb_result_o !== 16'h00C8) begin
               n_bad++;
               $display("FAIL single_fields got src=%0d res=%h required 1 00c8",
                        bus.cdb_src_o, bus.cdb_result_o);
            end
         end
      end
      drain("single");
   endtask

   task automatic test_contention();
      apply_reset();
      for (int b = 0; b < 2; b++) begin
         glog.delete();
         for (int s = 0; s < NS; s++)
            put(s, 4'(s + 4*b), 5'(s + 8), 16'((s + 1 + 4*b) * 10), 4'(s), 1'b1);
         step();
         idle();
         drain("contention");
         n_cmp++;
         if (glog.size() != NS) begin
            n_bad++;
            $display("FAIL contention_count burst=%0d got=%0d required %0d",
                     b, glog.size(), NS);
         end else begin
            for (int i = 0; i < NS; i++) begin
               n_cmp++;
               if (glog[i] != i) begin
                  n_bad++;
                  $display("FAIL contention_order burst=%0d beat=%0d got=%0d required %0d",
                           b, i, glog[i], i);
               end
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      bit af_seen = 1'b0;
      apply_reset();
      glog.delete();
      for (int c = 0; c < 6; c++) begin
         put(0, 4'(c), 5'd1, 16'(16'h2000 + c), 4'h1, 1'b1);
         put(2, 4'(c + 8), 5'd2, 16'(16'h2200 + c), 4'h2, 1'b1);
         step();
         if (bus.src_afull_o[2] === 1'b1) af_seen = 1'b1;
      end
      idle();
      drain("b2b");
      n_cmp += 3;
      if (!af_seen) begin
         n_bad++; $display("FAIL b2b_afull2 got=0 required 1");
      end
      if (bus.overflow_o !== 1'b0) begin
         n_bad++; $display("FAIL b2b_ovf got=%b required 0", bus.overflow_o);
      end
      if (glog.size() != 12) begin
         n_bad++; $display("FAIL b2b_count got=%0d required 12", glog.size());
      end else begin
         for (int i = 0; i < 12; i++) begin
            n_cmp++;
            if (glog[i] != ((i % 2) ? 2 : 0)) begin
               n_bad++;
               $display("FAIL b2b_alt beat=%0d got=%0d required %0d",
                        i, glog[i], (i % 2) ? 2 : 0);
            end
         end
      end
   endtask

   task automatic test_overflow();
      logic [3:0] dm [8];
      for (int c = 0; c < 8; c++) dm[c] = 4'b0000;
`ifdef WB_BYPASS_EN
      dm[5] = 4'b1100; dm[6] = 4'b1011; dm[7] = 4'b0111;
`else
      dm[5] = 4'b1110; dm[6] = 4'b1101; dm[7] = 4'b1011;
`endif
      apply_reset();
      for (int c = 0; c < 8; c++) begin
         for (int s = 0; s < NS; s++)
            put(s, 4'(c), 5'(s), 16'(16'h3000 + c*16 + s), 4'(c), !dm[c][s]);
         if (c == 5) begin
            n_cmp++;
            if (bus.overflow_o !== 1'b0) begin
               n_bad++; $display("FAIL ovf_early got=%b required 0", bus.overflow_o);
            end
         end
         if (c == 6) begin
            n_cmp++;
            if (bus.overflow_o !== 1'b1) begin
               n_bad++; $display("FAIL ovf_set got=%b required 1", bus.overflow_o);
            end
         end
         step();
      end
      idle();
      drain("ovf");
      n_cmp++;
      if (bus.overflow_o !== 1'b1) begin
         n_bad++; $display("FAIL ovf_sticky got=%b required 1", bus.overflow_o);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_cmp++;
      if (bus.overflow_o !== 1'b0) begin
         n_bad++; $display("FAIL ovf_clear got=%b required 0", bus.overflow_o);
      end
   endtask

   task automatic test_mispredict();
      bit v_seen = 1'b0;
      apply_reset();
      for (int c = 0; c < 3; c++) begin
         put(1, 4'(c), 5'd4, 16'(16'h4100 + c), 4'h1, 1'b1);
         put(3, 4'(c), 5'd6, 16'(16'h4300 + c), 4'h3, 1'b1);
         step();
      end
      idle();
`ifndef WB_BYPASS_EN
      n_cmp++;
      if (bus.src_afull_o[1] !== 1'b1) begin
         n_bad++; $display("FAIL mp_pre_afull got=%b required 1", bus.src_afull_o[1]);
      end
`endif
      bus.mispredict_i = 1'b1;
      put(0, 4'hF, 5'd31, 16'hDEAD, 4'hF, 1'b0);
      step();
      idle();
      clear_sb();
      for (int k = 0; k < 6; k++) begin
         if (bus.cdb_v_o !== 1'b0) v_seen = 1'b1;
         step();
      end
      n_cmp += 3;
      if (v_seen) begin
         n_bad++; $display("FAIL mp_cdb_v got=1 required 0");
      end
      if (bus.src_afull_o !== 4'd0) begin
         n_bad++; $display("FAIL mp_afull got=%b required 0", bus.src_afull_o);
      end
      if (bus.overflow_o !== 1'b0) begin
         n_bad++; $display("FAIL mp_ovf got=%b required 0", bus.overflow_o);
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      put(2, 4'd2, 5'd9, 16'h5200, 4'h2, 1'b1);
      put(3, 4'd3, 5'd10, 16'h5300, 4'h3, 1'b1);
      step();
      rst = 1'b1;
      idle();
      clear_sb();
      step();
      rst = 1'b0;
      n_cmp += 2;
      if (bus.cdb_v_o !== 1'b0) begin
         n_bad++; $display("FAIL rmid_v got=%b required 0", bus.cdb_v_o);
      end
      if (bus.src_afull_o !== 4'd0) begin
         n_bad++; $display("FAIL rmid_afull got=%b required 0", bus.src_afull_o);
      end
      repeat (3) step();
      glog.delete();
      put(3, 4'd7, 5'd11, 16'h5301, 4'h3, 1'b1);
      put(0, 4'd8, 5'd12, 16'h5001, 4'h0, 1'b1);
      step();
      idle();
      drain("rmid");
      n_cmp++;
      if (glog.size() != 2 || glog[0] != 0 || glog[1] != 3) begin
         n_bad++;
         $display("FAIL rmid_prio got=%0d beats first=%0d required 2 beats 0 then 3",
                  glog.size(), (glog.size() > 0) ? glog[0] : -1);
      end
   endtask

   initial begin
      bus.wb_v_i        = '0;
      bus.wb_rob_dest_i = '0;
      bus.wb_reg_dest_i = '0;
      bus.wb_result_i   = '0;
      bus.wb_flags_i    = '0;
      bus.mispredict_i  = 1'b0;
      test_reset();
      test_single();
      test_contention();
      test_back_to_back();
      test_overflow();
      test_mispredict();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
